// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory controller: access sizes, FSM states, byte enables.
package mem_ctrl_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;
    localparam logic [1:0] SizeBad  = 2'b11;

    // Byte-enable constants; BeNone marks a read strobe
    localparam logic [3:0] BeNone  = 4'b0000;
    localparam logic [3:0] BeByte0 = 4'b0001;
    localparam logic [3:0] BeLo    = 4'b0011;
    localparam logic [3:0] BeHi    = 4'b1100;
    localparam logic [3:0] BeAll   = 4'b1111;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRdIssue,
        StRdWait,
        StResp,
        StErr
    } state_e;

    // Byte enables for a store of the given size at the given byte lane
    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SizeByte: be = BeByte0 << lane;
            SizeHalf: be = lane[1] ? BeHi : BeLo;
            default:  be = BeAll;
        endcase
        return be;
    endfunction

    // Right-justified store data replicated across every lane
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SizeByte: d = {4{wdata[7:0]}};
            SizeHalf: d = {2{wdata[15:0]}};
            default:  d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_ctrl_load_align.sv
// Picks the addressed byte/half/word out of an SRAM word and zero/sign-extends it.
module load_align
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] value_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select followed by extension; word loads pass straight through
    always_comb begin
        byte_v  = word_i[{addr_i, 3'b000} +: 8];
        half_v  = addr_i[1] ? word_i[31:16] : word_i[15:0];
        value_o = word_i;
        case (size_i)
            SizeByte: value_o = {{24{signed_i & byte_v[7]}}, byte_v};
            SizeHalf: value_o = {{16{signed_i & half_v[15]}}, half_v};
            default:  value_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Single-outstanding load/store controller between a core request port and a
// synchronous single-port SRAM with one-cycle read latency.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 3072,
    parameter int unsigned WADDR_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic               req_signed,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    output logic               rsp_err,
    output logic [31:0]        rsp_rdata,
    output logic               sram_en,
    output logic [3:0]         sram_be,
    output logic [WADDR_W-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata
);

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [1:0]         size_q, size_d;
    logic               signed_q, signed_d;
    logic [WADDR_W+1:0] addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        load_value;
    logic               illegal;

    load_align u_load_align (
        .word_i   (sram_rdata),
        .addr_i   (addr_q[1:0]),
        .size_i   (size_q),
        .signed_i (signed_q),
        .value_o  (load_value)
    );

    // Classify the request currently on the port; only consulted at the handshake
    always_comb begin
        illegal = 1'b0;
        if (req_size == SizeBad) illegal = 1'b1;
        if (req_size == SizeHalf && req_addr[0]) illegal = 1'b1;
        if (req_size == SizeWord && req_addr[1:0] != 2'b00) illegal = 1'b1;
        if (req_addr[31:2] >= 30'(MEM_WORDS)) illegal = 1'b1;
    end

    // Next-state, request capture and all port outputs
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        signed_d   = signed_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_err    = 1'b0;
        sram_en    = 1'b0;
        sram_be    = BeNone;
        sram_addr  = '0;
        sram_wdata = '0;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr[WADDR_W+1:0];
                    wdata_d  = req_wdata;
                    if (illegal) begin
                        state_d = StErr;
                        rdata_d = '0;
                    end else if (req_we) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRdIssue;
                    end
                end
            end
            StWr: begin
                sram_en    = 1'b1;
                sram_be    = store_be(size_q, addr_q[1:0]);
                sram_addr  = addr_q[WADDR_W+1:2];
                sram_wdata = store_data(size_q, wdata_q);
                // Store responses carry zero read data
                rdata_d    = '0;
                state_d    = StResp;
            end
            StRdIssue: begin
                sram_en   = 1'b1;
                sram_addr = addr_q[WADDR_W+1:2];
                state_d   = StRdWait;
            end
            StRdWait: begin
                rdata_d = load_value;
                state_d = StResp;
            end
            StResp: begin
                rsp_valid = 1'b1;
                state_d   = StIdle;
            end
            StErr: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        rsp_rdata = rdata_q;
    end

    // State and latched request registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            size_q   <= SizeByte;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule
